// File: rtl/rv_pkg.sv
// Shared rv32i definitions: register address type, x0 constant, default XLEN,
// and address classification helpers used by the register file.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0 = 5'd0;

    // Address maps to an implemented register (x0 included).
    function automatic logic addr_in_range(input reg_addr_t a, input int unsigned depth);
        return (32'(a) < depth);
    endfunction

    // Address maps to a writable, trackable register (implemented and not x0).
    function automatic logic addr_live(input reg_addr_t a, input int unsigned depth);
        return (32'(a) < depth) && (a != X0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the register file.
// Holds one busy bit per architectural register, sets it on an accepted
// reservation, clears it on writeback or flush, and answers busy lookups.
//   clk, rst       : clock, async active-high reset
//   i_rs_raddr     : read-port addresses to look up
//   o_rs_busy      : per read port, addressed register has a pending write
//   i_rd_waddr/i_rd_wvalid : writeback ports (clear busy)
//   i_rsv_valid/i_rsv_addr : reservation request
//   o_rsv_ready    : reservation can be accepted this cycle
//   i_flush        : clear all busy bits
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_RD-1:0][REG_ADDR_W-1:0]    i_rs_raddr,
    output logic [NUM_RD-1:0]                    o_rs_busy,
    input  logic [NUM_WR-1:0][REG_ADDR_W-1:0]    i_rd_waddr,
    input  logic [NUM_WR-1:0]                    i_rd_wvalid,
    input  logic                                 i_rsv_valid,
    input  logic [REG_ADDR_W-1:0]                i_rsv_addr,
    output logic                                 o_rsv_ready,
    input  logic                                 i_flush
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // WAW stall: a register with a pending write cannot be reserved again.
    // Looks only at the stored bits so same-cycle writes do not affect it.
    always_comb begin
        o_rsv_ready = 1'b0;
        if (addr_in_range(i_rsv_addr, DEPTH)) begin
            o_rsv_ready = !busy_q[IDX_W'(i_rsv_addr)];
        end
    end

    // Next busy vector: flush beats write clears, an accepted set beats both.
    always_comb begin
        busy_d = busy_q;
        if (i_flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (i_rd_wvalid[p] && addr_live(i_rd_waddr[p], DEPTH)) begin
                    busy_d[IDX_W'(i_rd_waddr[p])] = 1'b0;
                end
            end
        end
        // x0 reservations are accepted but never tracked.
        if (i_rsv_valid && o_rsv_ready && (i_rsv_addr != X0)) begin
            busy_d[IDX_W'(i_rsv_addr)] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Busy lookup; with bypass a same-cycle write shows the cleared value.
    always_comb begin
        o_rs_busy = '0;
        for (int r = 0; r < int'(NUM_RD); r++) begin
            if (addr_live(i_rs_raddr[r], DEPTH)) begin
                o_rs_busy[r] = busy_q[IDX_W'(i_rs_raddr[r])];
                if (BYPASS != 0) begin
                    for (int p = 0; p < int'(NUM_WR); p++) begin
                        if (i_rd_wvalid[p] && (i_rd_waddr[p] == i_rs_raddr[r])) begin
                            o_rs_busy[r] = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file for the rv32i core with hardwired x0,
// optional write-to-read bypass and a pending-write scoreboard.
//   clk, rst      : clock, async active-high reset
//   i_rs_raddr    : NUM_RD read addresses
//   o_rs_rdata    : NUM_RD combinational read data
//   o_rs_busy     : NUM_RD pending-write flags for the read addresses
//   i_rd_waddr/i_rd_wvalid/i_rd_wdata : NUM_WR writeback ports
//   i_rsv_valid/i_rsv_addr/o_rsv_ready : destination reservation handshake
//   i_flush       : clear all busy bits (contents untouched)
module regfile_mp
    import rv_pkg::*;
#(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_RD-1:0][REG_ADDR_W-1:0]    i_rs_raddr,
    output logic [NUM_RD-1:0][XLEN-1:0]          o_rs_rdata,
    output logic [NUM_RD-1:0]                    o_rs_busy,
    input  logic [NUM_WR-1:0][REG_ADDR_W-1:0]    i_rd_waddr,
    input  logic [NUM_WR-1:0]                    i_rd_wvalid,
    input  logic [NUM_WR-1:0][XLEN-1:0]          i_rd_wdata,
    input  logic                                 i_rsv_valid,
    input  logic [REG_ADDR_W-1:0]                i_rsv_addr,
    output logic                                 o_rsv_ready,
    input  logic                                 i_flush
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0] regs_q [DEPTH];
    logic [XLEN-1:0] regs_d [DEPTH];

    // Write arbitration: ports applied in ascending order so the highest wins.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (i_rd_wvalid[p] && addr_live(i_rd_waddr[p], DEPTH)) begin
                regs_d[IDX_W'(i_rd_waddr[p])] = i_rd_wdata[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: x0 and unimplemented registers read zero.
    always_comb begin
        o_rs_rdata = '0;
        for (int r = 0; r < int'(NUM_RD); r++) begin
            if (addr_live(i_rs_raddr[r], DEPTH)) begin
                o_rs_rdata[r] = regs_q[IDX_W'(i_rs_raddr[r])];
                if (BYPASS != 0) begin
                    for (int p = 0; p < int'(NUM_WR); p++) begin
                        if (i_rd_wvalid[p] && (i_rd_waddr[p] == i_rs_raddr[r])) begin
                            o_rs_rdata[r] = i_rd_wdata[p];
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_rs_raddr  (i_rs_raddr),
        .o_rs_busy   (o_rs_busy),
        .i_rd_waddr  (i_rd_waddr),
        .i_rd_wvalid (i_rd_wvalid),
        .i_rsv_valid (i_rsv_valid),
        .i_rsv_addr  (i_rsv_addr),
        .o_rsv_ready (o_rsv_ready),
        .i_flush     (i_flush)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Instance A: RV32I, 2 read / 2 write ports,
// bypass on. Instance B: RV32E, 2 read / 1 write port, bypass off.
module tb_regfile_mp;

    logic clk;
    logic rst;

    logic [1:0][4:0]  a_raddr;
    logic [1:0][31:0] a_rdata;
    logic [1:0]       a_busy;
    logic [1:0][4:0]  a_waddr;
    logic [1:0]       a_wvalid;
    logic [1:0][31:0] a_wdata;
    logic             a_rsv_valid;
    logic [4:0]       a_rsv_addr;
    logic             a_rsv_ready;
    logic             a_flush;

    logic [1:0][4:0]  b_raddr;
    logic [1:0][31:0] b_rdata;
    logic [1:0]       b_busy;
    logic [0:0][4:0]  b_waddr;
    logic [0:0]       b_wvalid;
    logic [0:0][31:0] b_wdata;
    logic             b_rsv_valid;
    logic [4:0]       b_rsv_addr;
    logic             b_rsv_ready;
    logic             b_flush;

    int checks;
    int errors;

    regfile_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst),
        .i_rs_raddr(a_raddr), .o_rs_rdata(a_rdata), .o_rs_busy(a_busy),
        .i_rd_waddr(a_waddr), .i_rd_wvalid(a_wvalid), .i_rd_wdata(a_wdata),
        .i_rsv_valid(a_rsv_valid), .i_rsv_addr(a_rsv_addr), .o_rsv_ready(a_rsv_ready),
        .i_flush(a_flush)
    );

    regfile_mp #(.XLEN(32), .DEPTH(16), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst),
        .i_rs_raddr(b_raddr), .o_rs_rdata(b_rdata), .o_rs_busy(b_busy),
        .i_rd_waddr(b_waddr), .i_rd_wvalid(b_wvalid), .i_rd_wdata(b_wdata),
        .i_rsv_valid(b_rsv_valid), .i_rsv_addr(b_rsv_addr), .o_rsv_ready(b_rsv_ready),
        .i_flush(b_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ops();
        a_wvalid = '0; a_rsv_valid = 1'b0; a_flush = 1'b0;
        b_wvalid = '0; b_rsv_valid = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_raddr = '0; a_waddr = '0; a_wdata = '0; a_rsv_addr = '0;
        b_raddr = '0; b_waddr = '0; b_wdata = '0; b_rsv_addr = '0;
        clr_ops();

        // Reset state
        a_raddr[0] = 5'd5; b_raddr[0] = 5'd5;
        a_rsv_addr = 5'd3; b_rsv_addr = 5'd3;
        tick();
        #1;
        chk("rst_a_rdata", a_rdata[0], 32'h0);
        chk("rst_a_busy", 32'(a_busy), 32'h0);
        chk("rst_a_ready", 32'(a_rsv_ready), 32'h1);
        chk("rst_b_ready", 32'(b_rsv_ready), 32'h1);
        tick();
        rst = 1'b0;

        // Same-cycle write/read of x5: bypass vs stored value
        a_waddr[0] = 5'd5; a_wdata[0] = 32'h1234_5678; a_wvalid = 2'b01;
        b_waddr[0] = 5'd5; b_wdata[0] = 32'h1234_5678; b_wvalid = 1'b1;
        #1;
        chk("byp_a_same", a_rdata[0], 32'h1234_5678);
        chk("nobyp_b_same", b_rdata[0], 32'h0);
        tick();
        clr_ops();
        #1;
        chk("byp_a_next", a_rdata[0], 32'h1234_5678);
        chk("nobyp_b_next", b_rdata[0], 32'h1234_5678);

        // Reserve x3, re-reserve stalls, write clears busy
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd3;
        b_rsv_valid = 1'b1; b_rsv_addr = 5'd3;
        #1;
        chk("rsv3_a_ready", 32'(a_rsv_ready), 32'h1);
        tick();
        a_raddr[0] = 5'd3; b_raddr[0] = 5'd3;
        #1;
        chk("rsv3_a_busy", 32'(a_busy[0]), 32'h1);
        chk("rsv3_b_busy", 32'(b_busy[0]), 32'h1);
        chk("rerv3_a_ready", 32'(a_rsv_ready), 32'h0);
        chk("rerv3_b_ready", 32'(b_rsv_ready), 32'h0);
        a_waddr[0] = 5'd3; a_wdata[0] = 32'hA5; a_wvalid = 2'b01;
        b_waddr[0] = 5'd3; b_wdata[0] = 32'hA5; b_wvalid = 1'b1;
        #1;
        chk("wr3_a_busy_byp", 32'(a_busy[0]), 32'h0);
        chk("wr3_a_rdata_byp", a_rdata[0], 32'hA5);
        chk("wr3_b_busy", 32'(b_busy[0]), 32'h1);
        chk("wr3_b_rdata", b_rdata[0], 32'h0);
        chk("wr3_a_ready_indep", 32'(a_rsv_ready), 32'h0);
        tick();
        clr_ops();
        #1;
        chk("wr3_a_busy_after", 32'(a_busy[0]), 32'h0);
        chk("wr3_b_busy_after", 32'(b_busy[0]), 32'h0);
        chk("wr3_a_ready_after", 32'(a_rsv_ready), 32'h1);
        chk("wr3_b_ready_after", 32'(b_rsv_ready), 32'h1);
        chk("wr3_b_rdata_after", b_rdata[0], 32'hA5);

        // Dual-write conflict on x7: port 1 wins
        a_waddr[0] = 5'd7; a_wdata[0] = 32'h1;
        a_waddr[1] = 5'd7; a_wdata[1] = 32'h2;
        a_wvalid = 2'b11; a_raddr[1] = 5'd7;
        #1;
        chk("dual_x7_byp", a_rdata[1], 32'h2);
        tick();
        clr_ops();
        #1;
        chk("dual_x7_stored", a_rdata[1], 32'h2);

        // Write x4 clears while x9 reservation sets
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd4;
        b_rsv_valid = 1'b1; b_rsv_addr = 5'd4;
        tick();
        a_rsv_addr = 5'd9; b_rsv_addr = 5'd9;
        a_waddr[0] = 5'd4; a_wdata[0] = 32'h44; a_wvalid = 2'b01;
        b_waddr[0] = 5'd4; b_wdata[0] = 32'h44; b_wvalid = 1'b1;
        tick();
        clr_ops();
        a_raddr[0] = 5'd4; a_raddr[1] = 5'd9;
        b_raddr[0] = 5'd4; b_raddr[1] = 5'd9;
        #1;
        chk("clr4_set9_a", 32'(a_busy), 32'h2);
        chk("clr4_set9_b", 32'(b_busy), 32'h2);

        // Set and clear of x6 in one cycle: set wins
        a_waddr[0] = 5'd6; a_wdata[0] = 32'h66; a_wvalid = 2'b01;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd6;
        b_waddr[0] = 5'd6; b_wdata[0] = 32'h66; b_wvalid = 1'b1;
        b_rsv_valid = 1'b1; b_rsv_addr = 5'd6;
        tick();
        clr_ops();
        a_raddr[0] = 5'd6; b_raddr[0] = 5'd6;
        #1;
        chk("setwin6_a_busy", 32'(a_busy[0]), 32'h1);
        chk("setwin6_a_rdata", a_rdata[0], 32'h66);
        chk("setwin6_b_busy", 32'(b_busy[0]), 32'h1);

        // Flush with same-cycle reservation of x2: only x2 busy afterwards
        a_flush = 1'b1; a_rsv_valid = 1'b1; a_rsv_addr = 5'd2;
        b_flush = 1'b1; b_rsv_valid = 1'b1; b_rsv_addr = 5'd2;
        tick();
        clr_ops();
        a_raddr[0] = 5'd2; a_raddr[1] = 5'd9;
        b_raddr[0] = 5'd2; b_raddr[1] = 5'd9;
        #1;
        chk("flush_a_x2_x9", 32'(a_busy), 32'h1);
        chk("flush_b_x2_x9", 32'(b_busy), 32'h1);
        a_raddr[0] = 5'd6; a_raddr[1] = 5'd7;
        #1;
        chk("flush_a_x6_x7", 32'(a_busy), 32'h0);
        chk("flush_a_keep_x7", a_rdata[1], 32'h2);
        chk("flush_a_keep_x6", a_rdata[0], 32'h66);

        // RV32E bounds on B
        b_raddr[0] = 5'd20;
        b_waddr[0] = 5'd20; b_wdata[0] = 32'hFFFF_FFFF; b_wvalid = 1'b1;
        b_rsv_valid = 1'b1; b_rsv_addr = 5'd20;
        #1;
        chk("e_rd20", b_rdata[0], 32'h0);
        chk("e_busy20", 32'(b_busy[0]), 32'h0);
        chk("e_ready20", 32'(b_rsv_ready), 32'h0);
        tick();
        clr_ops();
        b_raddr[1] = 5'd4;
        #1;
        chk("e_rd20_after", b_rdata[0], 32'h0);
        chk("e_x4_intact", b_rdata[1], 32'h44);
        chk("e_x4_not_busy", 32'(b_busy[1]), 32'h0);

        // x0: writes ignored, reservation accepted but untracked
        a_waddr[0] = 5'd0; a_wdata[0] = 32'hDEAD_BEEF; a_wvalid = 2'b01;
        b_waddr[0] = 5'd0; b_wdata[0] = 32'hDEAD_BEEF; b_wvalid = 1'b1;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd0;
        a_raddr[0] = 5'd0; b_raddr[0] = 5'd0;
        #1;
        chk("x0_a_same", a_rdata[0], 32'h0);
        chk("x0_a_ready", 32'(a_rsv_ready), 32'h1);
        tick();
        clr_ops();
        #1;
        chk("x0_a_after", a_rdata[0], 32'h0);
        chk("x0_b_after", b_rdata[0], 32'h0);
        chk("x0_a_busy", 32'(a_busy[0]), 32'h0);
        chk("x0_a_ready_after", 32'(a_rsv_ready), 32'h1);

        // Asynchronous reset mid-run discards pending ops
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd8;
        tick();
        clr_ops();
        a_raddr[0] = 5'd8;
        #1;
        chk("pre_rst_busy8", 32'(a_busy[0]), 32'h1);
        a_waddr[0] = 5'd10; a_wdata[0] = 32'h1010; a_wvalid = 2'b01;
        a_rsv_valid = 1'b1; a_rsv_addr = 5'd8;
        a_raddr[1] = 5'd5; b_raddr[1] = 5'd5;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_a_x5", a_rdata[1], 32'h0);
        chk("arst_b_x5", b_rdata[1], 32'h0);
        chk("arst_a_busy8", 32'(a_busy[0]), 32'h0);
        chk("arst_a_ready8", 32'(a_rsv_ready), 32'h1);
        tick();
        clr_ops();
        rst = 1'b0;
        a_raddr[0] = 5'd10;
        #1;
        chk("arst_x10_dropped", a_rdata[0], 32'h0);
        tick();
        a_raddr[0] = 5'd8;
        #1;
        chk("arst_rsv8_dropped", 32'(a_busy[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
